// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake between the execute stage (master) and the
// load/store controller (slave).
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller: one request at a time, drives the data memory port
// and shared tri-state bus, extends load data, returns result or error.
module lsu_mem_ctrl #(
  parameter int ADDR_WIDTH  = 7,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  lsu_mem_ctrl_if.slave         lsu,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [2:0]            mem_ctrl,
  output logic                  mem_we,
  inout  wire  [31:0]           mem_data
);

  typedef enum logic [2:0] {IDLE, SETUP, WRITE, WAIT, READ, RESP} state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] wdata_q;
  logic [3:0]  wait_cnt;
  logic        req_err;

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b100:  return {24'd0, d[7:0]};
      3'b101:  return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    req_err = |(lsu.req_addr >> ADDR_WIDTH);
    case (lsu.req_funct3)
      3'b000:  req_err = req_err;
      3'b001:  req_err = req_err | lsu.req_addr[0];
      3'b010:  req_err = req_err | (|lsu.req_addr[1:0]);
      3'b100:  req_err = req_err | lsu.req_store;
      3'b101:  req_err = req_err | lsu.req_store | lsu.req_addr[0];
      default: req_err = 1'b1;
    endcase
  end

  // The bus is only ever driven while the write pulse is high.
  assign mem_data = mem_we ? wdata_q : 32'bz;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      lsu.req_ready  <= 1'b0;
      lsu.resp_valid <= 1'b0;
      lsu.resp_rdata <= '0;
      lsu.resp_err   <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_ctrl       <= '0;
      store_q        <= 1'b0;
      funct3_q       <= '0;
      wdata_q        <= '0;
      wait_cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          lsu.req_ready <= 1'b1;
          if (lsu.req_valid && lsu.req_ready) begin
            lsu.req_ready <= 1'b0;
            store_q       <= lsu.req_store;
            funct3_q      <= lsu.req_funct3;
            wdata_q       <= lsu.req_wdata;
            if (req_err) begin
              lsu.resp_valid <= 1'b1;
              lsu.resp_err   <= 1'b1;
              lsu.resp_rdata <= '0;
              state          <= RESP;
            end else begin
              mem_addr <= lsu.req_addr[ADDR_WIDTH-1:0];
              mem_ctrl <= {lsu.req_funct3[1:0], 1'b0};
              state    <= SETUP;
            end
          end
        end
        SETUP: begin
          if (store_q) begin
            mem_we <= 1'b1;
            state  <= WRITE;
          end else if (WAIT_CYCLES > 0) begin
            wait_cnt <= WAIT_INIT;
            state    <= WAIT;
          end else begin
            state <= READ;
          end
        end
        WRITE: begin
          mem_we         <= 1'b0;
          lsu.resp_valid <= 1'b1;
          lsu.resp_err   <= 1'b0;
          lsu.resp_rdata <= '0;
          state          <= RESP;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= READ;
        end
        READ: begin
          lsu.resp_valid <= 1'b1;
          lsu.resp_err   <= 1'b0;
          lsu.resp_rdata <= extend(funct3_q, mem_data);
          state          <= RESP;
        end
        RESP: begin
          // Ready rises together with the return to IDLE so a store can recur every 4 cycles.
          if (lsu.resp_ready) begin
            lsu.resp_valid <= 1'b0;
            lsu.resp_err   <= 1'b0;
            lsu.resp_rdata <= '0;
            lsu.req_ready  <= 1'b1;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
